alu_seq_nbit: RTL and testbench
===============================

ALU_SEQ_NBIT -- requirements
Module: alu_seq_nbit

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 op  input  3  opcode: 000 AND, 001 OR, 010 MUL, 011 ADD, 100 SUB (see REQ-027), others reserved.
REQ-009 out_valid  output  1  res holds a completed result.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 res  output  2*WIDTH  result, registered.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states IDLE, EXEC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 Acceptance: a rising edge with in_valid && in_ready; a, b, op are captured at that edge; later input changes have no effect on the accepted operation.
REQ-015 AND/OR/ADD/SUB/reserved: IDLE->DONE at acceptance edge; out_valid high in the cycle immediately after acceptance (latency 1).
REQ-016 MUL: IDLE->EXEC at acceptance; one shift-add iteration per cycle for exactly WIDTH edges; EXEC->DONE on the WIDTH-th EXEC edge; out_valid high WIDTH+1 cycles after acceptance.
REQ-017 AND/OR: res = zero-extended bitwise a&b / a|b.
REQ-018 ADD: res = zero-extended a+b, carry in bit WIDTH, no overflow possible.
REQ-019 MUL: res = full unsigned 2*WIDTH-bit product, no truncation.
REQ-020 Reserved opcodes: res = 0, latency 1, out_valid asserted normally.
REQ-021 DONE->IDLE on the edge where out_valid && out_ready; res and out_valid hold stable while out_ready low (unbounded backpressure).
REQ-022 No acceptance while busy; in_valid in EXEC/DONE is ignored and not queued.
REQ-023 res retains last completed value in IDLE and EXEC; it updates only on entry to DONE.

Reset
REQ-024 rst_n low forces, asynchronously: state IDLE, res 0, out_valid 0, busy 0, in_ready 1 (once released), internal multiplier counter/accumulator 0.
REQ-025 Reset during EXEC or DONE discards the operation; no result is produced after release.
REQ-026 First acceptance possible on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro ALU_SEQ_SUB_EN: when defined, op 100 yields res = (a-b) as 2*WIDTH-bit two's complement (sign-extended); when undefined, op 100 is reserved per REQ-020; no other behaviour changes.

Structure
REQ-028 Package alu_seq_pkg holds opcode constants (OP_AND..OP_SUB) and the FSM state enum; RTL and bench import it.
REQ-029 Multiplier iteration is sub-module alu_seq_mul (start, operands, done, product), instantiated once; counter width $clog2(WIDTH+1).

Verification (WIDTH=4 unless stated)
REQ-030 ADD a=F, b=F, out_ready=1 -> out_valid 1 cycle after accept, res=8'h1E, then in_ready back high.
REQ-031 MUL a=F, b=F -> busy for 5 cycles, out_valid 5 cycles after accept, res=8'hE1; in_valid pulses during EXEC ignored.
REQ-032 AND a=A, b=6 with out_ready low 10 cycles -> res=8'h02 stable, out_valid held, in_ready 0 throughout, IDLE one edge after out_ready rises.
REQ-033 MUL a=7, b=3, rst_n low in 2nd EXEC cycle -> res=0, out_valid 0, no later result; next ADD 1+2 -> res=8'h03.
REQ-034 SUB a=3, b=5: with ALU_SEQ_SUB_EN -> res=8'hFE; without -> res=8'h00; op 111 -> res=8'h00 in both builds.
REQ-035 WIDTH=8 MUL a=FF, b=FF -> res=16'hFE01 after 9 cycles; random 1000-op regression vs reference model under random backpressure.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle,
// WIDTH cycles per operation. o_product is the accumulator value including
// the current iteration, so it is the full product in the cycle o_done is high.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic                 r_run;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   w_acc_nxt;

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_done    = r_run && (r_cnt == LAST);
    assign o_product = w_acc_nxt;

    // Load operands on start, then shift multiplicand left / multiplier right each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (r_run) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (o_done) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq_nbit.sv
// Sequential N-bit ALU with valid/ready handshakes on both sides.
// AND/OR/ADD (and SUB) complete in one cycle; MUL runs WIDTH cycles in alu_seq_mul.
// Build option: define ALU_SEQ_SUB_EN to enable op 100 as sign-extended a-b;
// otherwise op 100 behaves like any reserved opcode (result 0).
module alu_seq_nbit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   res,
    output logic                 busy
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_res;
    logic [2*WIDTH-1:0]   w_quick_res;
    logic [2*WIDTH-1:0]   w_mul_prod;
    logic                 w_accept;
    logic                 w_mul_start;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_b_ext;

    assign w_a_ext     = {{WIDTH{1'b0}}, a};
    assign w_b_ext     = {{WIDTH{1'b0}}, b};
    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_mul_start = w_accept && (op == OP_MUL);
    assign res         = r_res;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    // Single-cycle results, computed straight from the inputs at acceptance.
    always_comb begin
        w_quick_res = '0;
        case (op)
            OP_AND:  w_quick_res = w_a_ext & w_b_ext;
            OP_OR:   w_quick_res = w_a_ext | w_b_ext;
            OP_ADD:  w_quick_res = w_a_ext + w_b_ext;
`ifdef ALU_SEQ_SUB_EN
            OP_SUB:  w_quick_res = w_a_ext - w_b_ext;
`endif
            default: w_quick_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept) w_state_nxt = (op == OP_MUL) ? ST_EXEC : ST_DONE;
            end
            ST_EXEC: begin
                if (w_mul_done) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Result register only changes on entry to DONE; it holds through IDLE/EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
        end else if (w_accept && (op != OP_MUL)) begin
            r_res <= w_quick_res;
        end else if ((r_state == ST_EXEC) && w_mul_done) begin
            r_res <= w_mul_prod;
        end
    end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Scoreboard bench for alu_seq_nbit: WIDTH=4 directed + random traffic with
// backpressure, plus a WIDTH=8 instance for the wide multiply case.
module tb_alu_seq_nbit;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv4 = 1'b0, or4 = 1'b0, ir4, ov4, busy4;
    logic [3:0] a4 = '0, b4 = '0;
    logic [2:0] op4 = '0;
    logic [7:0] res4;

    logic       iv8 = 1'b0, or8 = 1'b0, ir8, ov8, busy8;
    logic [7:0] a8 = '0, b8 = '0;
    logic [2:0] op8 = '0;
    logic [15:0] res8;

    alu_seq_nbit #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .op(op4),
        .out_valid(ov4), .out_ready(or4), .res(res4), .busy(busy4));

    alu_seq_nbit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .op(op8),
        .out_valid(ov8), .out_ready(or8), .res(res8), .busy(busy8));

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] sbq[$];
    logic [7:0]  last_res = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic [2:0] o);
        int ix, iy;
        ix = int'(x);
        iy = int'(y);
        case (o)
            OP_AND: return {4'h0, x & y};
            OP_OR:  return {4'h0, x | y};
            OP_MUL: return 8'(ix * iy);
            OP_ADD: return 8'(ix + iy);
`ifdef ALU_SEQ_SUB_EN
            OP_SUB: return 8'(ix - iy);
`endif
            default: return 8'h00;
        endcase
    endfunction

    // One transaction on the WIDTH=4 DUT: drive, measure latency, apply bp cycles
    // of backpressure, complete the handshake and confirm return to IDLE.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb, input logic [2:0] top,
                         input logic [7:0] exp_in, input int bp, input bit poke);
        int n;
        int lat;
        logic [15:0] exp;
        lat = (top == OP_MUL) ? 5 : 1;
        @(negedge clk);
        chk("in_ready_idle", 32'(ir4), 32'd1);
        a4 = ta; b4 = tb; op4 = top; iv4 = 1'b1; or4 = (bp == 0);
        sbq.push_back({8'h00, exp_in});
        @(posedge clk); #1;
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); op4 = 3'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            iv4 = 1'b0;
            if (!ov4) begin
                chk("busy_exec", 32'(busy4), 32'd1);
                chk("in_ready_exec", 32'(ir4), 32'd0);
                chk("res_hold_exec", 32'(res4), 32'(last_res));
                if (poke) begin
                    iv4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); op4 = 3'($urandom);
                end
            end
        end while (!ov4 && n < 40);
        iv4 = 1'b0;
        chk("latency", 32'(n), 32'(lat));
        exp = sbq.pop_front();
        chk("res", 32'(res4), 32'(exp));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(ov4), 32'd1);
            chk("bp_res_stable", 32'(res4), 32'(exp));
            chk("bp_in_ready", 32'(ir4), 32'd0);
        end
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        chk("idle_in_ready", 32'(ir4), 32'd1);
        chk("idle_out_valid", 32'(ov4), 32'd0);
        chk("idle_res_keep", 32'(res4), 32'(exp));
        last_res = exp[7:0];
    endtask

    initial begin
        int n;
        logic [3:0] ra, rb;
        logic [2:0] rop;

        // Reset values while rst_n is low.
        repeat (2) @(negedge clk);
        chk("rst_res", 32'(res4), 32'd0);
        chk("rst_out_valid", 32'(ov4), 32'd0);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_res8", 32'(res8), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // First request lands on the first rising edge after release.
        do_op(4'hF, 4'hF, OP_ADD, 8'h1E, 0, 1'b0);
        do_op(4'hF, 4'hF, OP_MUL, 8'hE1, 0, 1'b1);
        do_op(4'hA, 4'h6, OP_AND, 8'h02, 10, 1'b0);

        // Reset in the second EXEC cycle of a multiply discards it.
        @(negedge clk);
        a4 = 4'h7; b4 = 4'h3; op4 = OP_MUL; iv4 = 1'b1;
        @(posedge clk); #1 iv4 = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("abort_res", 32'(res4), 32'd0);
        chk("abort_out_valid", 32'(ov4), 32'd0);
        chk("abort_busy", 32'(busy4), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        last_res = 8'h00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(ov4), 32'd0);
        end
        do_op(4'h1, 4'h2, OP_ADD, 8'h03, 0, 1'b0);

`ifdef ALU_SEQ_SUB_EN
        do_op(4'h3, 4'h5, OP_SUB, 8'hFE, 1, 1'b0);
`else
        do_op(4'h3, 4'h5, OP_SUB, 8'h00, 1, 1'b0);
`endif
        do_op(4'h3, 4'h5, 3'b111, 8'h00, 0, 1'b0);
        do_op(4'h9, 4'h4, OP_OR, 8'h0D, 2, 1'b0);

        // WIDTH=8 full-width multiply.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; op8 = OP_MUL; iv8 = 1'b1; or8 = 1'b1;
        sbq.push_back(16'hFE01);
        @(posedge clk); #1 iv8 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov8 && n < 40);
        chk("w8_latency", 32'(n), 32'd9);
        chk("w8_res", 32'(res8), 32'(sbq.pop_front()));
        @(negedge clk);
        or8 = 1'b0;
        chk("w8_idle", 32'(ir8), 32'd1);

        // Random regression against the reference model with random backpressure.
        for (int k = 0; k < 1000; k++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rop = 3'($urandom_range(0, 7));
            do_op(ra, rb, rop, ref4(ra, rb, rop), $urandom_range(0, 3), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
